// File: rtl/aes_req_queue.sv
// aes_req_queue: assembles byte-serial AES instructions into words and queues them FWFT for the AES FSM
// clk, rst_n       : clock, asynchronous active-low reset
// in_valid/in_byte : host byte stream, byte 0 is the instruction LSB
// in_abort         : drops the partially assembled instruction
// in_ready         : low only while the completing byte waits for a free slot
// req_valid/req_data/ready_req_in : head entry to the FSM, popped on valid && ready
// count/full/empty : FIFO occupancy; frame_busy : partial instruction held
module aes_req_queue #(
  parameter int ADDRW = 24,
  parameter int DEPTH = 4,
  localparam int IW = 3 * ADDRW + 2,
  localparam int NBYTES = (IW + 7) / 8,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [7:0]    in_byte,
  input  logic          in_abort,
  output logic          in_ready,
  output logic          req_valid,
  output logic [IW-1:0] req_data,
  input  logic          ready_req_in,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          frame_busy
);
  localparam int PW = CW - 1;
  localparam int BW = $clog2(NBYTES + 1);
  localparam int LB = 8 * (NBYTES - 1);
  logic [BW-1:0] byte_cnt_q, byte_cnt_d;
  logic [IW-1:0] shreg_q, shreg_d, asm_w;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [IW-1:0] mem_q [DEPTH];
  logic last, acc, push, pop, unused_in;
  assign last = byte_cnt_q == BW'(NBYTES - 1);
  assign full = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
  assign in_ready = !(last && full);
  assign acc = in_valid && in_ready && !in_abort;
  assign push = acc && last;
  assign pop = !empty && ready_req_in;
  assign req_valid = !empty;
  assign req_data = empty ? '0 : mem_q[rd_ptr_q];
  assign count = count_q;
  assign frame_busy = byte_cnt_q != '0;
  // upper bits of the final byte are architecturally ignored
  assign unused_in = ^in_byte;
  always_comb begin
    asm_w = shreg_q;
    for (int k = 0; k < NBYTES - 1; k++)
      if (byte_cnt_q == BW'(k)) asm_w[8*k +: 8] = in_byte;
    asm_w[IW-1:LB] = last ? in_byte[IW-1-LB:0] : shreg_q[IW-1:LB];
    byte_cnt_d = (in_abort || push) ? '0 : acc ? byte_cnt_q + BW'(1) : byte_cnt_q;
    shreg_d = (in_abort || push) ? '0 : acc ? asm_w : shreg_q;
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d = count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_q <= '0;
      shreg_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      shreg_q <= shreg_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  // storage is deliberately not reset; req_data is masked while empty
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= asm_w;
  end
endmodule

// File: tb/tb_aes_req_queue.sv
// tb_aes_req_queue: directed plus random checks of aes_req_queue against a queue-based model
module tb_aes_req_queue;
  localparam int IW = 3 * 24 + 2;
  localparam int NB = (IW + 7) / 8;
  localparam int DEPTH = 4;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_abort = 0, ready_req_in = 0, in_ready;
  logic [7:0] in_byte = 0;
  logic req_valid, full, empty, frame_busy;
  logic [IW-1:0] req_data;
  logic [2:0] count;
  int n_chk = 0, n_fail = 0;
  logic [IW-1:0] q[$];
  logic [7:0] part[$];
  aes_req_queue dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_byte(in_byte), .in_abort(in_abort),
    .in_ready(in_ready), .req_valid(req_valid), .req_data(req_data), .ready_req_in(ready_req_in),
    .count(count), .full(full), .empty(empty), .frame_busy(frame_busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic model_ready();
    return !(part.size() == NB - 1 && q.size() == DEPTH);
  endfunction
  task automatic cycle(input logic v, input logic [7:0] b, input logic ab, input logic rdy);
    logic er;
    logic [IW-1:0] w;
    @(negedge clk);
    in_valid = v; in_byte = b; in_abort = ab; ready_req_in = rdy;
    #1;
    er = model_ready();
    chk("in_ready", 80'(in_ready), 80'(er));
    chk("req_valid", 80'(req_valid), 80'(q.size() != 0));
    chk("req_data", 80'(req_data), (q.size() != 0) ? 80'(q[0]) : 80'(0));
    chk("count", 80'(count), 80'(q.size()));
    chk("full", 80'(full), 80'(q.size() == DEPTH));
    chk("empty", 80'(empty), 80'(q.size() == 0));
    chk("frame_busy", 80'(frame_busy), 80'(part.size() != 0));
    @(posedge clk);
    if (q.size() != 0 && rdy) void'(q.pop_front());
    if (ab) part.delete();
    else if (v && er) begin
      part.push_back(b);
      if (part.size() == NB) begin
        w = '0;
        foreach (part[i]) w |= IW'(part[i]) << (8 * i);
        q.push_back(w);
        part.delete();
      end
    end
  endtask
  task automatic frame(input int pct);
    logic [7:0] b;
    logic a;
    int tries;
    for (int i = 0; i < NB; i++) begin
      b = 8'($urandom);
      tries = 0;
      do begin
        a = model_ready();
        cycle(1, b, 0, $urandom_range(1, 100) <= pct);
        tries++;
      end while (!a && tries < 50);
      chk("stall_bound", 80'(a), 80'(1));
    end
  endtask
  task automatic drain();
    int g = 0;
    while (q.size() != 0 && g < 20) begin
      cycle(0, 0, 0, 1);
      g++;
    end
    chk("drain_bound", 80'(q.size()), 80'(0));
  endtask
  task automatic rst_chk(input string tag);
    chk({tag, "_in_ready"}, 80'(in_ready), 80'(1));
    chk({tag, "_req_valid"}, 80'(req_valid), 80'(0));
    chk({tag, "_req_data"}, 80'(req_data), 80'(0));
    chk({tag, "_count"}, 80'(count), 80'(0));
    chk({tag, "_full"}, 80'(full), 80'(0));
    chk({tag, "_empty"}, 80'(empty), 80'(1));
    chk({tag, "_frame_busy"}, 80'(frame_busy), 80'(0));
  endtask
  initial begin
    repeat (2) @(negedge clk);
    #1 rst_chk("reset");
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < NB - 1; i++) cycle(1, 8'(i + 1), 0, 0);
    cycle(1, 8'h02, 0, 0);
    #1;
    chk("t1_valid", 80'(req_valid), 80'(1));
    chk("t1_data", 80'(req_data), 80'(74'h2_0908_0706_0504_0302_01));
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
    repeat (DEPTH) frame(0);
    for (int i = 0; i < NB - 1; i++) cycle(1, 8'($urandom), 0, 0);
    cycle(1, 8'h5C, 0, 0);
    cycle(1, 8'h5C, 0, 0);
    cycle(1, 8'h5C, 0, 1);
    cycle(1, 8'h5C, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    for (int i = 0; i < NB; i++) cycle(1, 8'($urandom), 0, i == NB - 1);
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 8'($urandom), 0, 0);
    cycle(1, 8'hAA, 1, 0);
    cycle(0, 0, 0, 0);
    frame(0);
    drain();
    repeat (9) frame(50);
    drain();
    frame(0);
    frame(0);
    for (int i = 0; i < 6; i++) cycle(1, 8'($urandom), 0, 0);
    @(negedge clk);
    #2 rst_n = 0;
    #1 rst_chk("async_rst");
    q.delete();
    part.delete();
    in_valid = 0; in_abort = 0; ready_req_in = 0;
    @(negedge clk) rst_n = 1;
    frame(0);
    drain();
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 31) == 0, $urandom_range(0, 1) == 1);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/aes_req_queue.md
Name: aes_req_queue

Overview:
- Instruction request queue directly upstream of the AES control FSM.
- Assembles AES instructions from a byte-serial host stream (CPU/SPI front end) into full-width instruction words.
- Buffers the words in a first-word-fall-through FIFO.
- Presents the head entry to the FSM on req_valid/req_data. The FSM's ready output is wired to ready_req_in and acts as the dequeue strobe.

Parameters:
- ADDRW, 24: address width. Instruction width IW = 3*ADDRW+2.
- DEPTH, 4: FIFO entries; must be a power of 2, at least 2.
- Derived localparam NBYTES = ceil(IW/8), which is 10 at the default.
- Derived localparam CW = clog2(DEPTH)+1.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  host byte valid
- in_byte  in  8  host instruction byte
- in_abort  in  1  discard the partially assembled instruction
- in_ready  out  1  queue can accept in_byte this cycle
- req_valid  out  1  FIFO non-empty; head entry on req_data
- req_data  out  IW  head instruction {op bit, key addr, text addr, dest addr} (MSB to LSB), as consumed by the FSM
- ready_req_in  in  1  consumer ready; pop occurs when req_valid && ready_req_in
- count  out  CW  number of FIFO entries held
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- frame_busy  out  1  byte counter non-zero (partial instruction held)

Behaviour:

Reset (async, rst_n low):
- byte_cnt=0, shreg=0, rd_ptr=wr_ptr=0, count=0.
- Outputs: req_valid=0, empty=1, full=0, frame_busy=0.
- in_ready=1.
- req_data=0. FIFO storage is not reset, but req_data is forced to 0 while empty.

Byte assembly:
- A byte is accepted when in_valid && in_ready && !in_abort.
- Byte k (k = 0..NBYTES-1) maps to instruction bits [8k+7:8k], so byte 0 is the LSB.
- In the final byte only bits [IW-1-8*(NBYTES-1):0] are used; the remaining upper bits are ignored. At the default, in_byte[1:0] map to bits 73:72.
- Bytes 0..NBYTES-2 are stored into shreg and byte_cnt increments.
- On acceptance of byte NBYTES-1:
  - The word {in_byte, shreg} (truncated to IW) is written to mem[wr_ptr] on that same edge.
  - wr_ptr increments (wrapping mod DEPTH) and byte_cnt returns to 0.
  - req_valid is visible on the next cycle, giving 1-cycle write-to-read latency.
- in_ready = !(byte_cnt == NBYTES-1 && full). It is registered-state only, with no combinational path from ready_req_in.
- When full, in_ready stays high for bytes 0..NBYTES-2. Only the completing byte stalls; it is held until a pop frees a slot, and is accepted the cycle after that pop.

in_abort:
- Synchronous. Sets byte_cnt=0 and clears shreg.
- Takes priority over an in_valid byte in the same cycle; that byte is dropped.
- Never alters FIFO contents or count.

Read side:
- req_valid = !empty. req_data = mem[rd_ptr], read combinationally from registered storage.
- A pop advances rd_ptr (wrapping mod DEPTH).
- req_data must hold stable while req_valid && !ready_req_in.

Count and flags:
- Push only: count+1. Pop only: count-1. Push and pop in the same cycle: count unchanged, and both pointers advance.
- Push and pop in the same cycle while count == 1 keeps req_valid high, with the new head shown the next cycle.
- Push while full is impossible because in_ready is low.
- A pop while empty is ignored, since req_valid is low.

Pointers:
- CW-1 bits each, wrapping naturally.
- full and empty are derived from count, not from pointer comparison.

Test Plan:
1. Single instruction (ADDRW=24):
   - Stimulus: 10 bytes 0x01..0x09 then 0x02, ready_req_in=0.
   - Response: req_valid rises the cycle after byte 9, and req_data = 74'h2_0908_0706_0504_0302_01 (bits 73:72 = 2'b10). Raise ready_req_in for 1 cycle: count 1->0, req_valid=0.
2. Fill to full:
   - Stimulus: push 4 instructions, then bytes 0..8 of a fifth.
   - Response: full=1, count=4, in_ready=1 through byte 8, then in_ready=0 with byte 9 held. Pop once: the next cycle in_ready=1 and byte 9 is accepted; count returns to 4 and FIFO order is preserved.
3. Simultaneous push/pop:
   - Stimulus: count=2, final byte accepted in the same cycle as a pop.
   - Response: count stays 2, and req_data advances to the next-oldest entry.
4. Abort:
   - Stimulus: send 5 bytes, then in_abort together with in_valid carrying 0xAA.
   - Response: frame_busy=0 and count unchanged. A following clean 10-byte frame reads back exactly, with no 0xAA and no stale bytes.
5. Wrap-around:
   - Stimulus: 9 push/pop cycles through DEPTH=4.
   - Response: every entry is read in order with correct data, and count never exceeds 4.
6. Reset mid-frame:
   - Stimulus: assert rst_n low after 6 bytes with 2 entries queued.
   - Response: req_valid=0, count=0, frame_busy=0, in_ready=1 immediately (asynchronous). The next frame assembles from byte 0.
